watch_adjust_ctrl: RTL and testbench
====================================

# watch_adjust_ctrl

Sequences time-setting of the watch datapath. Turns debounced button levels into a one-hot digit select plus single-cycle inc/dec/clear pulses for `watch_dp`. Adds press-and-hold auto-repeat, digit rotation and an idle timeout back to run mode. It sits between the button debouncers and `watch_dp`/`fnd_controller`, and replaces the plain watch control unit when `sw[1]` selects watch mode.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles U/D must stay held before auto-repeat starts (0.5 s at 100 MHz).
- `REPEAT_CYCLES`, default 10_000_000: cycles between auto-repeat pulses (0.1 s).
- `TIMEOUT_CYCLES`, default 1_000_000_000: cycles with no button high before adjust mode is left (10 s).
- `clk`  in  1  system clock; the block uses this single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  watch mode selected (`sw[1]`).
- `btn_L`, `btn_R`, `btn_U`, `btn_D`  in  1 each  debounced button levels.
- `adjust_digit_sel`  out  4  one-hot selected field: [0] msec, [1] sec, [2] min, [3] hour. 0000 = not adjusting.
- `inc`  out  1  single-cycle increment pulse to the selected field.
- `dec`  out  1  single-cycle decrement pulse.
- `clear`  out  1  single-cycle watch clear pulse.
- `adjusting`  out  1  high while in ADJ state.

## Operation
- All outputs are registered. Reset values: `adjust_digit_sel`=0000, `inc`=0, `dec`=0, `clear`=0, `adjusting`=0. State is RUN and all counters are 0.
- Rising edge of a button = sampled 1 now while its previous-sample register holds 0. Previous-sample registers reset to 1, so a button already held at reset does not produce an edge.
- State RUN (`adjusting`=0, sel=0000):
  - L rise → ADJ with sel=1000 (hour).
  - D rise while U is high → `clear` pulse.
  - All other inputs are ignored. No `inc`/`dec` is ever issued in RUN.
- State ADJ (`adjusting`=1). Priority order, highest first:
  1. `enable`=0 → RUN immediately. sel=0000, no pulses, repeat and timeout counters cleared. `enable`=0 forces RUN from any state, every cycle.
  2. L rise and R rise in the same cycle → RUN.
  3. L rise → sel rotates toward hour (0001→0010→0100→1000→0001).
  4. R rise → sel rotates toward msec (1000→0100→0010→0001→1000).
  5. U/D handling:
     - U rise → `inc`. D rise → `dec`.
     - U and D both high → no pulses and both repeat engines reset; this holds for simultaneous rises as well.
     - Rotating the digit resets both repeat engines. A held U/D therefore does not repeat onto the new digit until it is released and pressed again.
- Auto-repeat, per button:
  - First pulse on the rising edge.
  - If the button is still held, the next pulse comes HOLD_CYCLES cycles later, then one every REPEAT_CYCLES cycles.
  - Release resets the engine.
- Timeout:
  - Counter clears on any cycle where any button is high; otherwise it increments.
  - On reaching TIMEOUT_CYCLES-1 → RUN, sel=0000.
- `inc` and `dec` are never high in the same cycle. `clear` is never high in ADJ.

## Timing
- Edge-to-pulse latency: an input rise sampled at edge k drives its output pulse high from edge k to edge k+1. Every pulse is exactly 1 cycle wide.
- State and `adjust_digit_sel` change at the same edge that samples the triggering input.
- Repeat schedule for U rising at edge k and held: `inc` at k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, and so on.
- Counters are `$clog2(param)` bits wide and saturate, never wrapping.
- `rst` has priority over everything. Reset mid-repeat or mid-adjust returns all outputs to their reset values at that edge.

## Structure
- Package `watch_adjust_pkg`:
  - state enum {RUN, ADJ}
  - digit one-hot localparams: SEL_MSEC, SEL_SEC, SEL_MIN, SEL_HOUR, SEL_NONE.
- One sub-module, `btn_repeat`: edge detect plus HOLD/REPEAT counter. It takes a level, an `en` and a `kick` reset, and outputs one pulse. Instantiated twice, for U and D.
- The top-level FSM contains the L/R edge detect, digit rotation and timeout counter.

## Test plan
Parameters for all scenarios: HOLD=8, REPEAT=4, TIMEOUT=32.
- Enter and rotate: reset, `enable`=1, pulse L → sel=1000, `adjusting`=1. L twice more → 0001 then 0010. R once → 0001.
- Auto-repeat: in ADJ, hold U for 20 cycles starting at edge k → `inc` at k, k+8, k+12, k+16, and no others. Release → no further pulses.
- Conflict: hold U, then raise D while U is still held → no `dec`, and repeat stops. Simultaneous U/D rise → no pulse.
- Exit paths:
  - L and R rising in the same cycle → RUN, sel=0000.
  - Separately, 32 idle cycles in ADJ → RUN.
  - Separately, `enable`→0 mid-repeat → RUN and no pulse in that cycle.
- Clear: in RUN, hold U and pulse D → one `clear` cycle and no `dec`. The same sequence in ADJ → `inc` only, no `clear`.
- Reset mid-operation: assert `rst` during a held-U repeat → all outputs 0 at that edge. Release `rst` with U still held → no `inc` until U is released and pressed again.

Source files
------------

// File: rtl/watch_adjust_pkg.sv
`default_nettype none
// ============================================================================
// Module   : watch_adjust_pkg
// Purpose  : Shared types and digit-select encodings for the watch adjust
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package watch_adjust_pkg;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        ADJ = 1'b1
    } state_t;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_MSEC = 4'b0001;
    localparam logic [3:0] SEL_SEC  = 4'b0010;
    localparam logic [3:0] SEL_MIN  = 4'b0100;
    localparam logic [3:0] SEL_HOUR = 4'b1000;

    // One step toward the hour field, hour wraps back to msec.
    function automatic logic [3:0] rotate_to_hour(input logic [3:0] sel);
        return {sel[2:0], sel[3]};
    endfunction

    // One step toward the msec field, msec wraps back to hour.
    function automatic logic [3:0] rotate_to_msec(input logic [3:0] sel);
        return {sel[0], sel[3:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/watch_adjust_ctrl_btn_repeat.sv
`default_nettype none
// ============================================================================
// Module   : btn_repeat
// Purpose  : Rising-edge detector with press-and-hold auto-repeat. Emits one
//            pulse on the press, another after HOLD_CYCLES of holding, then
//            one every REPEAT_CYCLES until release.
// Revision : 1.0 - initial release
// ============================================================================
module btn_repeat #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic en,
    input  logic kick,
    output logic pulse
);
    import watch_adjust_pkg::*;

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic          prev;
    logic          active;
    logic          repeating;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          rise;

    assign rise     = level & ~prev;
    // Saturating increment so the counter can never wrap.
    assign cnt_next = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    // Edge detect plus hold/repeat scheduling; prev resets high so a button
    // held through reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= 1'b1;
            active    <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
            pulse     <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= 1'b0;
            if (!en || kick) begin
                active    <= 1'b0;
                repeating <= 1'b0;
                cnt       <= '0;
            end else if (rise) begin
                pulse     <= 1'b1;
                active    <= 1'b1;
                repeating <= 1'b0;
                cnt       <= '0;
            end else if (active && level) begin
                if (!repeating) begin
                    if (cnt == HOLD_LAST) begin
                        pulse     <= 1'b1;
                        repeating <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end else begin
                    if (cnt == REPEAT_LAST) begin
                        pulse <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
            end else begin
                active    <= 1'b0;
                repeating <= 1'b0;
                cnt       <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/watch_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : watch_adjust_ctrl
// Purpose  : Time-setting sequencer for the watch datapath: digit select,
//            inc/dec with auto-repeat, clear, and idle timeout to run mode.
// Revision : 1.0 - initial release
// ============================================================================
module watch_adjust_ctrl #(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_L,
    input  logic       btn_R,
    input  logic       btn_U,
    input  logic       btn_D,
    output logic [3:0] adjust_digit_sel,
    output logic       inc,
    output logic       dec,
    output logic       clear,
    output logic       adjusting
);
    import watch_adjust_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          prev_l;
    logic          prev_r;
    logic          prev_d;
    logic [TW-1:0] idle_cnt;

    logic l_rise;
    logic r_rise;
    logic d_rise;
    logic exit_lr;
    logic any_btn;
    logic engine_en;
    logic engine_kick;

    assign l_rise  = btn_L & ~prev_l;
    assign r_rise  = btn_R & ~prev_r;
    assign d_rise  = btn_D & ~prev_d;
    assign exit_lr = l_rise & r_rise;
    assign any_btn = btn_L | btn_R | btn_U | btn_D;

    // Engines only run while adjusting and not leaving this cycle; a digit
    // rotation or a U+D conflict drops any press in progress.
    assign engine_en   = enable & (state == ADJ) & ~exit_lr;
    assign engine_kick = l_rise | r_rise | (btn_U & btn_D);

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep_up (
        .clk   (clk),
        .rst   (rst),
        .level (btn_U),
        .en    (engine_en),
        .kick  (engine_kick),
        .pulse (inc)
    );

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep_dn (
        .clk   (clk),
        .rst   (rst),
        .level (btn_D),
        .en    (engine_en),
        .kick  (engine_kick),
        .pulse (dec)
    );

    // RUN/ADJ state machine: entry, digit rotation, exits and idle timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            adjust_digit_sel <= SEL_NONE;
            adjusting        <= 1'b0;
            clear            <= 1'b0;
            idle_cnt         <= '0;
            prev_l           <= 1'b1;
            prev_r           <= 1'b1;
            prev_d           <= 1'b1;
        end else begin
            prev_l <= btn_L;
            prev_r <= btn_R;
            prev_d <= btn_D;
            clear  <= 1'b0;
            if (!enable) begin
                state            <= RUN;
                adjust_digit_sel <= SEL_NONE;
                adjusting        <= 1'b0;
                idle_cnt         <= '0;
            end else begin
                case (state)
                    RUN: begin
                        idle_cnt <= '0;
                        if (l_rise) begin
                            state            <= ADJ;
                            adjust_digit_sel <= SEL_HOUR;
                            adjusting        <= 1'b1;
                        end else if (d_rise && btn_U) begin
                            clear <= 1'b1;
                        end
                    end
                    ADJ: begin
                        if (exit_lr) begin
                            state            <= RUN;
                            adjust_digit_sel <= SEL_NONE;
                            adjusting        <= 1'b0;
                            idle_cnt         <= '0;
                        end else begin
                            if (l_rise) begin
                                adjust_digit_sel <= rotate_to_hour(adjust_digit_sel);
                            end else if (r_rise) begin
                                adjust_digit_sel <= rotate_to_msec(adjust_digit_sel);
                            end
                            if (any_btn) begin
                                idle_cnt <= '0;
                            end else if (idle_cnt == TIMEOUT_LAST) begin
                                state            <= RUN;
                                adjust_digit_sel <= SEL_NONE;
                                adjusting        <= 1'b0;
                                idle_cnt         <= '0;
                            end else if (idle_cnt != {TW{1'b1}}) begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state            <= RUN;
                        adjust_digit_sel <= SEL_NONE;
                        adjusting        <= 1'b0;
                        idle_cnt         <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_watch_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_adjust_ctrl
// Purpose  : Directed self-checking bench for watch_adjust_ctrl with
//            HOLD=8, REPEAT=4, TIMEOUT=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_watch_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       btn_L, btn_R, btn_U, btn_D;
    logic [3:0] adjust_digit_sel;
    logic       inc, dec, clear, adjusting;

    int compared   = 0;
    int mismatched = 0;

    watch_adjust_ctrl #(
        .HOLD_CYCLES    (8),
        .REPEAT_CYCLES  (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .btn_L            (btn_L),
        .btn_R            (btn_R),
        .btn_U            (btn_U),
        .btn_D            (btn_D),
        .adjust_digit_sel (adjust_digit_sel),
        .inc              (inc),
        .dec              (dec),
        .clear            (clear),
        .adjusting        (adjusting)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output vector {sel, inc, dec, clear, adjusting}.
    task automatic chk_all(input string tag, input logic [3:0] sel, input logic i,
                           input logic d, input logic c, input logic a);
        chk(tag, {adjust_digit_sel, inc, dec, clear, adjusting}, {sel, i, d, c, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b0;
        btn_L = 1'b0; btn_R = 1'b0; btn_U = 1'b0; btn_D = 1'b0;
        tick(); tick();
        chk_all("reset", 4'b0000, 0, 0, 0, 0);
        rst = 1'b0; enable = 1'b1;
        tick();
        chk_all("run_idle", 4'b0000, 0, 0, 0, 0);

        // Enter and rotate
        btn_L = 1; tick(); chk_all("enter_hour", 4'b1000, 0, 0, 0, 1);
        btn_L = 0; tick();
        btn_L = 1; tick(); chk_all("rot_l_1", 4'b0001, 0, 0, 0, 1);
        btn_L = 0; tick();
        btn_L = 1; tick(); chk_all("rot_l_2", 4'b0010, 0, 0, 0, 1);
        btn_L = 0; tick();
        btn_R = 1; tick(); chk_all("rot_r", 4'b0001, 0, 0, 0, 1);
        btn_R = 0; tick();

        // Auto-repeat: inc at k, k+8, k+12, k+16 over a 20-cycle hold
        btn_U = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("repeat_inc", {7'd0, inc}, {7'd0, (i == 0 || i == 8 || i == 12 || i == 16)});
            chk("repeat_dec", {7'd0, dec}, 8'd0);
        end
        btn_U = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("release_quiet", {6'd0, inc, dec}, 8'd0);
        end

        // Conflict: D while U held, then simultaneous rise
        btn_U = 1; tick(); chk_all("conf_u_rise", 4'b0001, 1, 0, 0, 1);
        tick();            chk_all("conf_u_hold", 4'b0001, 0, 0, 0, 1);
        btn_D = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("conf_both", {6'd0, inc, dec}, 8'd0);
        end
        btn_D = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("conf_u_after", {6'd0, inc, dec}, 8'd0);
        end
        btn_U = 0; tick();
        btn_U = 1; btn_D = 1; tick(); chk_all("simul_rise", 4'b0001, 0, 0, 0, 1);
        tick();                       chk_all("simul_hold", 4'b0001, 0, 0, 0, 1);
        btn_U = 0; btn_D = 0; tick();

        // U-held + D press in ADJ: inc only, never clear
        btn_U = 1; tick(); chk_all("adj_u", 4'b0001, 1, 0, 0, 1);
        btn_D = 1; tick(); chk_all("adj_ud", 4'b0001, 0, 0, 0, 1);
        btn_D = 0; tick();
        btn_U = 0; tick();

        // Plain decrement
        btn_D = 1; tick(); chk_all("dec_rise", 4'b0001, 0, 1, 0, 1);
        btn_D = 0; tick(); chk_all("dec_rel", 4'b0001, 0, 0, 0, 1);

        // Exit by L+R together
        btn_L = 1; btn_R = 1; tick(); chk_all("exit_lr", 4'b0000, 0, 0, 0, 0);
        btn_L = 0; btn_R = 0; tick();

        // Clear in RUN
        btn_U = 1; tick(); chk_all("run_u", 4'b0000, 0, 0, 0, 0);
        btn_D = 1; tick(); chk_all("run_clear", 4'b0000, 0, 0, 1, 0);
        tick();            chk_all("run_clear_1cyc", 4'b0000, 0, 0, 0, 0);
        btn_D = 0; btn_U = 0; tick();

        // Idle timeout: 31 idle cycles stay, the 32nd leaves
        btn_L = 1; tick(); chk_all("to_enter", 4'b1000, 0, 0, 0, 1);
        btn_L = 0;
        for (int i = 1; i <= 31; i++) tick();
        chk_all("to_31", 4'b1000, 0, 0, 0, 1);
        tick();
        chk_all("to_32", 4'b0000, 0, 0, 0, 0);

        // enable drop just as the first repeat pulse is due
        btn_L = 1; tick(); btn_L = 0; tick();
        btn_U = 1; tick(); chk_all("en_u_rise", 4'b1000, 1, 0, 0, 1);
        for (int i = 1; i <= 7; i++) tick();
        enable = 0; tick(); chk_all("en_drop", 4'b0000, 0, 0, 0, 0);
        enable = 1; btn_U = 0; tick();

        // Reset mid-repeat, then U held through reset release
        btn_L = 1; tick(); btn_L = 0; tick();
        btn_U = 1; tick(); chk_all("rst_u_rise", 4'b1000, 1, 0, 0, 1);
        for (int i = 1; i <= 7; i++) tick();
        rst = 1; tick(); chk_all("rst_mid", 4'b0000, 0, 0, 0, 0);
        rst = 0; tick();
        btn_L = 1; tick(); chk_all("rst_reenter", 4'b1000, 0, 0, 0, 1);
        btn_L = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_u_held", {7'd0, inc}, 8'd0);
        end
        btn_U = 0; tick();
        btn_U = 1; tick(); chk_all("rst_u_repress", 4'b1000, 1, 0, 0, 1);
        btn_U = 0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
